// File: rtl/tile_job_scheduler.sv
// ---------------------------------------------------------------------------
// tile_job_scheduler
//   Frame-level scheduler for the graphics cores. A host start pulse latches
//   a tile count and interrupt number. Tile indices are then handed to free
//   cores in round-robin order, at most one per cycle. A one-cycle
//   frame_done is raised once every dispatched tile has reported completion.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          synchronous active-low reset
//   i_frame_start    host start pulse, honoured only in IDLE
//   i_tile_count     tiles in the frame (latched with start)
//   i_int_vec        interrupt number for the cores (latched with start)
//   i_core_done      per-core one-cycle completion pulse
//   o_dispatch_valid one-hot, one cycle: start a tile on that core
//   o_dispatch_tile  tile index qualified by o_dispatch_valid
//   o_dispatch_int   latched interrupt number
//   o_busy           high while the FSM is in DISPATCH, DRAIN or DONE
//   o_frame_done     one-cycle frame completion pulse
//   o_timeout_err    sticky per-core watchdog flags
//
// Build option
//   TILE_SCHED_WATCHDOG_EN : per-core busy watchdog. When undefined,
//   o_timeout_err is tied low, and a core that never reports done stalls
//   the frame in DRAIN.
// ---------------------------------------------------------------------------
module tile_job_scheduler #(
  parameter int CORE_NUM    = 4,
  parameter int TILE_W      = 8,
  parameter int INT_NUM     = 3,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_start,
  input  logic [TILE_W-1:0]   i_tile_count,
  input  logic [INT_NUM-1:0]  i_int_vec,
  input  logic [CORE_NUM-1:0] i_core_done,
  output logic [CORE_NUM-1:0] o_dispatch_valid,
  output logic [TILE_W-1:0]   o_dispatch_tile,
  output logic [INT_NUM-1:0]  o_dispatch_int,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic [CORE_NUM-1:0] o_timeout_err
);

  localparam int PTR_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;

  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CORE_NUM-1:0] r_core_busy;
  logic [TILE_W-1:0]   r_next_tile, r_total, r_disp_tile;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [INT_NUM-1:0]  r_int;
  logic [CORE_NUM-1:0] r_disp_valid;
  logic                r_busy, r_frame_done;

  logic                w_found, w_grant;
  logic [PTR_W-1:0]    w_grant_idx, w_cand;
  logic [CORE_NUM-1:0] w_set, w_busy_clr, w_wdog_exp;

  // First free core at or above rr_ptr, wrapping.
  always_comb begin : p_rr
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < CORE_NUM; k++) begin
      w_cand = PTR_W'((int'(r_rr_ptr) + k) % CORE_NUM);
      if (!w_found && !r_core_busy[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_grant = (r_state == S_DISPATCH) && w_found && (r_next_tile < r_total);
  assign w_set   = w_grant ? (CORE_NUM'(1) << w_grant_idx) : '0;
  // Done on a non-busy core clears an already-clear bit, so it is a no-op.
  assign w_busy_clr = r_core_busy & ~i_core_done & ~w_wdog_exp;

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_frame_start)
          w_state_nxt = (i_tile_count != '0) ? S_DISPATCH : S_DONE;
      S_DISPATCH:
        if (w_grant && ((r_next_tile + TILE_W'(1)) == r_total))
          w_state_nxt = S_DRAIN;
      // Look at the post-clear mask, so that the last done pulse moves the
      // FSM to DONE on the same edge that clears it.
      S_DRAIN:
        if (w_busy_clr == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_core_busy  <= '0;
      r_next_tile  <= '0;
      r_total      <= '0;
      r_rr_ptr     <= '0;
      r_int        <= '0;
      r_disp_valid <= '0;
      r_disp_tile  <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_core_busy <= w_busy_clr | w_set;
      if (r_state == S_IDLE && i_frame_start && i_tile_count != '0) begin
        r_total     <= i_tile_count;
        r_int       <= i_int_vec;
        r_next_tile <= '0;
      end
      if (w_grant) begin
        r_next_tile <= r_next_tile + TILE_W'(1);
        r_rr_ptr    <= (int'(w_grant_idx) == CORE_NUM - 1) ? '0 : w_grant_idx + PTR_W'(1);
      end
      r_disp_valid <= w_set;
      r_disp_tile  <= w_grant ? r_next_tile : '0;
      r_busy       <= (w_state_nxt != S_IDLE);
      // frame_done trails the DONE state by one cycle.
      r_frame_done <= (r_state == S_DONE);
    end
  end

`ifdef TILE_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [CORE_NUM-1:0][WD_W-1:0] r_wdog;
  logic [CORE_NUM-1:0]           r_timeout;

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_wdog
    // Expire on the WDOG_CYCLES-th busy cycle; the counter is cleared on grant.
    assign w_wdog_exp[i] = r_core_busy[i] && !i_core_done[i] &&
                           (r_wdog[i] == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge i_clk) begin
      if (!i_rst_n)           r_wdog[i] <= '0;
      else if (w_set[i])      r_wdog[i] <= '0;
      else if (r_core_busy[i]) r_wdog[i] <= r_wdog[i] + WD_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                r_timeout <= '0;
    else if (r_state == S_IDLE && i_frame_start) r_timeout <= '0;
    else                                         r_timeout <= r_timeout | w_wdog_exp;
  end

  assign o_timeout_err = r_timeout;
`else
  assign w_wdog_exp    = '0;
  assign o_timeout_err = '0;
`endif

  assign o_dispatch_valid = r_disp_valid;
  assign o_dispatch_tile  = r_disp_tile;
  assign o_dispatch_int   = r_int;
  assign o_busy           = r_busy;
  assign o_frame_done     = r_frame_done;

endmodule

// File: tb/tb_tile_job_scheduler.sv
// Directed bench for tile_job_scheduler (default build, watchdog disabled).
// Cycle numbering: the frame_start pulse is cycle 0. Outputs are checked
// 1 ns after each rising edge, and inputs for that cycle are driven right
// after the check.
module tb_tile_job_scheduler;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic [7:0] tile_count;
  logic [2:0] int_vec;
  logic [3:0] core_done;
  logic [3:0] dv;
  logic [7:0] dtile;
  logic [2:0] dint;
  logic       busy;
  logic       fdone;
  logic [3:0] terr;

  int n_chk = 0;
  int n_err = 0;

  tile_job_scheduler dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_frame_start    (frame_start),
    .i_tile_count     (tile_count),
    .i_int_vec        (int_vec),
    .i_core_done      (core_done),
    .o_dispatch_valid (dv),
    .o_dispatch_tile  (dtile),
    .o_dispatch_int   (dint),
    .o_busy           (busy),
    .o_frame_done     (fdone),
    .o_timeout_err    (terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse frame_start during cycle 0; this returns in cycle 1.
  task automatic start_frame(input logic [7:0] tc, input logic [2:0] iv);
    frame_start = 1'b1;
    tile_count  = tc;
    int_vec     = iv;
    tick();
    frame_start = 1'b0;
  endtask

  logic [3:0] held;
  logic [3:0] exp_dv;
  int         exp_tile;
  int         n_fd;
  int         n_dv;

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; tile_count = '0; int_vec = '0; core_done = '0;
    tick(); tick(); tick();
    chk("rst_dv", dv, 0);
    chk("rst_tile", dtile, 0);
    chk("rst_int", dint, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", fdone, 0);
    chk("rst_terr", terr, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Empty frame: straight to DONE, frame_done in cycle 2.
    start_frame(8'd0, 3'd0);
    for (int c = 1; c <= 3; c++) begin
      chk("t1_dv", dv, 0);
      chk("t1_fd", fdone, (c == 2) ? 1 : 0);
      chk("t1_busy", busy, (c == 1) ? 1 : 0);
      tick();
    end

    // Four tiles, each core done three cycles after its dispatch.
    start_frame(8'd4, 3'd5);
    for (int c = 1; c <= 11; c++) begin
      chk("t2_dv", dv, (c >= 2 && c <= 5) ? (1 << (c - 2)) : 0);
      if (c >= 2 && c <= 5) chk("t2_tile", dtile, c - 2);
      chk("t2_fd", fdone, (c == 10) ? 1 : 0);
      chk("t2_busy", busy, (c <= 9) ? 1 : 0);
      if (c == 3) chk("t2_int", dint, 5);
      core_done = (c >= 5 && c <= 8) ? 4'(1 << (c - 5)) : 4'd0;
      tick();
    end
    core_done = '0;

    // Six tiles; cores 1 and 2 finish early and receive tiles 4 and 5.
    held = '0;
    start_frame(8'd6, 3'd2);
    for (int c = 1; c <= 13; c++) begin
      case (c)
        2: begin exp_dv = 4'b0001; exp_tile = 0; end
        3: begin exp_dv = 4'b0010; exp_tile = 1; end
        4: begin exp_dv = 4'b0100; exp_tile = 2; end
        5: begin exp_dv = 4'b1000; exp_tile = 3; end
        6: begin exp_dv = 4'b0010; exp_tile = 4; end
        7: begin exp_dv = 4'b0100; exp_tile = 5; end
        default: begin exp_dv = 4'b0000; exp_tile = 0; end
      endcase
      chk("t3_dv", dv, exp_dv);
      if (exp_dv != 0) chk("t3_tile", dtile, exp_tile);
      chk("t3_dbl", dv & held, 0);
      held = held | dv;
      chk("t3_fd", fdone, (c == 12) ? 1 : 0);
      chk("t3_busy", busy, (c <= 11) ? 1 : 0);
      case (c)
        4:  core_done = 4'b0010;
        5:  core_done = 4'b0100;
        10: core_done = 4'b1111;
        default: core_done = 4'b0000;
      endcase
      held = held & ~core_done;
      tick();
    end
    core_done = '0;

    // Two tiles starting at rr_ptr=3; a second start in DISPATCH is ignored.
    n_fd = 0; n_dv = 0;
    start_frame(8'd2, 3'd6);
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) chk("t4_dv2", dv, 4'b1000);
      if (c == 3) chk("t4_dv3", dv, 4'b0001);
      if (c == 4) chk("t4_int", dint, 6);
      chk("t4_busy", busy, (c <= 5) ? 1 : 0);
      if (fdone) n_fd++;
      if (dv != 0) n_dv++;
      if (c == 6) chk("t4_fd6", fdone, 1);
      frame_start = (c == 2);
      tile_count  = (c == 2) ? 8'd7 : 8'd2;
      int_vec     = (c == 2) ? 3'd1 : 3'd6;
      core_done   = (c == 4) ? 4'b1001 : 4'b0000;
      tick();
    end
    frame_start = 1'b0; core_done = '0;
    chk("t4_nfd", n_fd, 1);
    chk("t4_ndv", n_dv, 2);

    // Spurious done while idle.
    core_done = 4'b1111;
    tick();
    core_done = '0;
    for (int c = 0; c < 2; c++) begin
      chk("t5_sp_busy", busy, 0);
      chk("t5_sp_dv", dv, 0);
      chk("t5_sp_fd", fdone, 0);
      tick();
    end

    // One tile on core 1; a spurious done on core 0, then reset in DRAIN.
    start_frame(8'd1, 3'd3);
    tick();
    chk("t5_dv", dv, 4'b0010);
    core_done = 4'b0001;
    tick();
    core_done = '0;
    chk("t5_hold_busy", busy, 1);
    chk("t5_hold_fd", fdone, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_dv", dv, 0);
    chk("t5_rst_int", dint, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_fd", fdone, 0);
    n_fd = 0;
    for (int c = 0; c < 5; c++) begin
      if (fdone) n_fd++;
      chk("t5_post_busy", busy, 0);
      core_done = (c == 1) ? 4'b0010 : 4'b0000;
      tick();
    end
    chk("t5_nfd", n_fd, 0);

    // rr_ptr was cleared by reset: the next tile goes to core 0.
    start_frame(8'd1, 3'd4);
    tick();
    chk("t6_dv", dv, 4'b0001);
    core_done = 4'b0001;
    tick();
    core_done = '0;
    tick();
    chk("t6_fd", fdone, 1);
    chk("t6_terr", terr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
